// File: rtl/pipe_skid_stage_pkg.sv
// pipe_skid_stage_pkg: shared types, default widths and helpers for pipeline skid stages
//   skid_state_t    : EMPTY / MAIN (main entry only) / FULL (main + skid)
//   *_DEF           : default payload and counter widths
//   exmem_payload_t : EX/MEM payload, split into data and ctrl at the instantiation site
//   occ_of()        : entries held for a given state
package pipe_skid_stage_pkg;

    typedef enum logic [1:0] {EMPTY, MAIN, FULL} skid_state_t;

    localparam int DATA_W_DEF = 160;
    localparam int CTRL_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] npc;
        logic [31:0] store_data;
        logic [31:0] ext_imm;
        logic [4:0]  wreg;
        logic [26:0] rsvd;
    } exmem_data_t;

    typedef struct packed {
        logic        reg_wen;
        logic        mem_ren;
        logic        mem_wen;
        logic        halt;
        logic [11:0] rsvd;
    } exmem_ctrl_t;

    typedef struct packed {
        exmem_ctrl_t ctrl;
        exmem_data_t data;
    } exmem_payload_t;

    function automatic logic [1:0] occ_of(skid_state_t s);
        return (s == FULL) ? 2'd2 : (s == MAIN) ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register with optional 1-entry skid buffer
//   CLK, nRST                      : clock (posedge), async active-low reset
//   in_valid/in_ready/in_data/in_ctrl : upstream slot handshake and payload
//   squash_in                      : consume the upstream slot as a bubble
//   flush                          : kill every held entry (redirect)
//   out_valid/out_ready/out_data/out_ctrl : main entry handshake and payload
//   occupancy                      : entries held (0..2)
//   stall_cnt                      : saturating count of out_valid & !out_ready cycles
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CTRL_W  = CTRL_W_DEF,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              squash_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    skid_state_t       state, nxt;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic              in_ready_q;
    logic              in_fire, out_fire;
    logic              ld_in, ld_skid, ld_from_skid;

    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;
    assign occupancy = occ_of(state);
    // with a skid entry, in_ready is registered so out_ready never reaches upstream combinationally
    assign in_ready  = (SKID_EN != 0) ? in_ready_q : ((state == EMPTY) | out_ready);
    assign in_fire   = in_valid & in_ready & ~squash_in;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        nxt          = state;
        ld_in        = 1'b0;
        ld_skid      = 1'b0;
        ld_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                nxt   = in_fire ? MAIN : EMPTY;
                ld_in = in_fire;
            end
            MAIN: begin
                if (in_fire && out_fire) begin
                    ld_in = 1'b1;
                end else if (in_fire && SKID_EN != 0) begin
                    nxt     = FULL;
                    ld_skid = 1'b1;
                end else if (out_fire) begin
                    nxt = EMPTY;
                end
            end
            FULL: begin
                nxt          = out_fire ? MAIN : FULL;
                ld_from_skid = out_fire;
            end
            default: nxt = EMPTY;
        endcase
        // flush outranks every transition, including a same-cycle accept
        if (flush) begin
            nxt          = EMPTY;
            ld_in        = 1'b0;
            ld_skid      = 1'b0;
            ld_from_skid = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
            main_data  <= '0;
            main_ctrl  <= '0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
            stall_cnt  <= '0;
        end else begin
            state      <= nxt;
            in_ready_q <= (nxt != FULL);
            if (ld_in) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end else if (ld_from_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end else if (nxt == EMPTY) begin
                // data may go stale, but ctrl must never commit from an empty slot
                main_ctrl <= '0;
            end
            if (ld_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    a_hold_stable: assert property (@(posedge CLK) disable iff (!nRST)
        out_valid && !out_ready && !flush |=> $stable(out_data) && $stable(out_ctrl));

    a_ctrl_zero: assert property (@(posedge CLK) disable iff (!nRST)
        !out_valid |-> out_ctrl == '0);

    a_occupancy: assert property (@(posedge CLK) disable iff (!nRST)
        occupancy == occ_of(state) && occupancy <= ((SKID_EN != 0) ? 2'd2 : 2'd1));

endmodule
